traffic_conflict_monitor: RTL and testbench
===========================================

# traffic_conflict_monitor

Independent safety monitor on the six lamp signals a traffic-light controller drives (r1,y1,g1,r2,y2,g2). It sits beside the controller on the lamp bus. Each cycle it decodes the lamp pattern into a phase and checks it against the legal pattern set, the legal phase sequence and the minimum/maximum dwell times. On the first violation it latches a coded fault and drives a red-flash enable to the lamp drivers until software clears it.

## Interface
- MIN_GREEN, default 8: minimum cycles a green phase (RG, GR) must hold.
- MIN_YELLOW, default 4: minimum cycles a yellow phase (RY, YR) must hold.
- MAX_DWELL, default 200: cycles any single phase may hold before watchdog fault.
- DW, default 8: dwell counter width. Requires MIN_YELLOW ≤ MIN_GREEN < MAX_DWELL < 2^DW.
- FLASH_HALF, default 3: half-period of `flash` in cycles.

Ports:
- clk  in  1  system clock (1 MHz); single clock domain.
- reset_n  in  1  reset, asynchronous, active-low.
- r1, y1, g1, r2, y2, g2  in  1 each  lamp signals from the controller.
- clear_fault  in  1  synchronous, 1-cycle; clears latched fault and re-arms.
- phase  out  2  decoded phase of registered lamps: RG=0, RY=1, GR=2, YR=3.
- phase_valid  out  1  registered lamps form a legal pattern.
- fault  out  1  latched fault indication.
- fault_code  out  3  0 none, 1 illegal pattern, 2 bad sequence, 3 short yellow, 4 short green, 5 watchdog.
- flash  out  1  red-flash enable; toggles while `fault`=1.

## Operation
- Input stage: all six lamps are registered into lamp_q every cycle. All checks use lamp_q.
- Legal patterns, exactly one lamp per direction (lamp order r1 y1 g1 r2 y2 g2):
  - RG = 100_001
  - RY = 100_010
  - GR = 001_100
  - YR = 010_100
  - Any other value is illegal, including both-green, all-off and multiple lamps on one side.
- Legal sequence: RG→RY→GR→YR→RG only.
- Dwell counter: counts consecutive cycles lamp_q holds the current phase.
  - Loads 1 on entry to a phase.
  - Saturates at MAX_DWELL.
- Checks, evaluated in priority order 1 to 5 (lowest code wins if several fire in the same cycle):
  1. Illegal pattern: lamp_q is illegal.
  2. Bad sequence: lamp_q differs from the held phase and is not its legal successor.
  3. Short yellow: exit from RY/YR with dwell < MIN_YELLOW.
  4. Short green: exit from RG/GR with dwell < MIN_GREEN.
  5. Watchdog: dwell reaches MAX_DWELL with no change.
- Unqualified phase: the first legal phase after reset or clear is accepted without a sequence check. Its exit skips the sequence and min-dwell checks. Illegal-pattern and watchdog checks still apply.
- State machine: IDLE (pre-prime) → ARMED_UNQUAL → ARMED → FAULT.
  - IDLE→ARMED_UNQUAL on the first edge after reset.
  - ARMED_UNQUAL→ARMED on the first legal phase change.
  - Any check firing in ARMED_UNQUAL or ARMED → FAULT.
  - FAULT→ARMED_UNQUAL on clear_fault.
- FAULT state:
  - `fault_code` is frozen at the first fault; later violations are ignored.
  - Phase decode and dwell counter keep running.
- clear_fault:
  - In FAULT: clears the fault and re-arms.
  - In the same cycle as a new violation: the clear wins and the violation is discarded.
  - In other states: no effect.

## Timing
- Reset (async, immediate): fault=0, fault_code=0, flash=0, phase=0, phase_valid=0, lamp_q=0, dwell=0, state IDLE.
  - The lamp_q=0 reset value is never reported as illegal; checks are disabled in IDLE.
- Latency from lamp change to outputs:
  - Lamp change before edge k appears in lamp_q at edge k.
  - phase/phase_valid update at edge k+1.
  - fault/fault_code update at edge k+1.
- Watchdog: fires at the edge where dwell would reach MAX_DWELL, i.e. the MAX_DWELL-th cycle of an unchanged phase.
- Flash:
  - Goes 1 on the same edge `fault` rises.
  - Toggles every FLASH_HALF cycles while fault=1.
  - Returns to 0 on the edge that clears the fault.
- clear_fault sampled at edge n: fault=0, fault_code=0 and flash=0 after edge n.
- Reset asserted mid-operation: all outputs go to reset values immediately, independent of clk.

## Test plan
Bench parameters: MIN_GREEN=8, MIN_YELLOW=4, MAX_DWELL=20, FLASH_HALF=3.

- Legal cycling: RG 10 cycles, RY 5, GR 10, YR 5, repeated 3 times → fault=0 throughout; phase steps 0,1,2,3 with 2-cycle lag.
- Conflict: drive g1=g2=1 (001_001) for 1 cycle from ARMED → fault=1, fault_code=1 two edges later; flash pattern 1,1,1,0,0,0,1...
- Skipped yellow and priority:
  - RG 10 cycles then GR → fault_code=2.
  - Separately, RY held 2 cycles then GR → fault_code=3 (short yellow).
  - RG held 3 cycles then RY (armed) → fault_code=4.
- Watchdog: hold GR 20 cycles → fault_code=5 on the 20th cycle; a later illegal pattern leaves fault_code=5.
- Clear and re-arm: in FAULT, pulse clear_fault in the same cycle as an illegal→GR change → fault=0; next phase accepted unqualified; exit after 2 cycles gives no fault.
- Async reset mid-FAULT with flash=1 → all outputs 0 without a clk edge; first 6'b0 sample after release gives no fault.

Source files
------------

// File: rtl/traffic_conflict_monitor.sv
// traffic_conflict_monitor
//
// Independent safety monitor for the six lamp lines of a two-direction
// traffic-light controller. It registers the lamps, decodes them into a
// phase, and checks the pattern, the phase order and the dwell time of each
// phase. The first violation latches a coded fault and starts a red-flash
// enable that keeps running until software pulses clear_fault.
//
// Ports
//   clk          system clock, single domain
//   reset_n      asynchronous active-low reset
//   r1,y1,g1     lamps, direction 1
//   r2,y2,g2     lamps, direction 2
//   clear_fault  1-cycle pulse: clears a latched fault and re-arms
//   phase        decoded phase of the registered lamps (RG=0 RY=1 GR=2 YR=3)
//   phase_valid  registered lamps form a legal pattern
//   fault        latched fault indication
//   fault_code   0 none, 1 illegal, 2 sequence, 3 short yellow,
//                4 short green, 5 watchdog
//   flash        red-flash enable, toggles every FLASH_HALF cycles in fault
//   dbg_state    monitor state (0 idle, 1 armed-unqualified, 2 armed, 3 fault)
//
// Handshakes: none. Every input is sampled on each rising clk edge and every
// output is a flop (or a decode of flop state) updated on that edge.

module traffic_conflict_monitor #(
    parameter int MIN_GREEN  = 8,
    parameter int MIN_YELLOW = 4,
    parameter int MAX_DWELL  = 200,
    parameter int DW         = 8,
    parameter int FLASH_HALF = 3
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       r1,
    input  logic       y1,
    input  logic       g1,
    input  logic       r2,
    input  logic       y2,
    input  logic       g2,
    input  logic       clear_fault,
    output logic [1:0] phase,
    output logic       phase_valid,
    output logic       fault,
    output logic [2:0] fault_code,
    output logic       flash,
    output logic [1:0] dbg_state
);

    localparam int FW = (FLASH_HALF > 1) ? $clog2(FLASH_HALF) : 1;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_UNQUAL = 2'd1;
    localparam logic [1:0] ST_ARMED  = 2'd2;
    localparam logic [1:0] ST_FAULT  = 2'd3;

    // Lamp order {r1,y1,g1,r2,y2,g2}
    localparam logic [5:0] PAT_RG = 6'b100_001;
    localparam logic [5:0] PAT_RY = 6'b100_010;
    localparam logic [5:0] PAT_GR = 6'b001_100;
    localparam logic [5:0] PAT_YR = 6'b010_100;

    localparam logic [2:0] FC_NONE     = 3'd0;
    localparam logic [2:0] FC_ILLEGAL  = 3'd1;
    localparam logic [2:0] FC_SEQUENCE = 3'd2;
    localparam logic [2:0] FC_SHORT_Y  = 3'd3;
    localparam logic [2:0] FC_SHORT_G  = 3'd4;
    localparam logic [2:0] FC_WATCHDOG = 3'd5;

    logic [5:0]    lamp_q, lamp_d;
    logic [1:0]    phase_q, phase_d;
    logic          phase_valid_q, phase_valid_d;
    logic [DW-1:0] dwell_q, dwell_d;
    logic [1:0]    state_q, state_d;
    logic [2:0]    fault_code_q, fault_code_d;
    logic          flash_q, flash_d;
    logic [FW-1:0] flash_cnt_q, flash_cnt_d;

    logic          cur_legal;
    logic [1:0]    cur_phase;
    logic [1:0]    next_phase;
    logic          changed;
    logic          same;
    logic          qualified;
    logic [2:0]    viol_code;

    // Decode of the registered lamps
    always_comb begin
        cur_legal = 1'b1;
        cur_phase = 2'd0;
        case (lamp_q)
            PAT_RG:  cur_phase = 2'd0;
            PAT_RY:  cur_phase = 2'd1;
            PAT_GR:  cur_phase = 2'd2;
            PAT_YR:  cur_phase = 2'd3;
            default: cur_legal = 1'b0;
        endcase
    end

    always_comb begin
        lamp_d     = {r1, y1, g1, r2, y2, g2};
        next_phase = phase_q + 2'd1;
        // changed/same are relative to the phase currently being held;
        // with no held phase (after an illegal pattern) neither is true.
        changed    = phase_valid_q && cur_legal && (cur_phase != phase_q);
        same       = phase_valid_q && cur_legal && (cur_phase == phase_q);
        // The first phase after reset/clear is unqualified: its exit skips
        // the sequence and minimum-dwell checks.
        qualified  = (state_q == ST_ARMED);

        // Phase decode and dwell run in every state, including FAULT.
        phase_valid_d = cur_legal;
        phase_d       = cur_legal ? cur_phase : phase_q;
        if (!cur_legal) begin
            dwell_d = '0;
        end else if (same) begin
            dwell_d = (dwell_q >= DW'(MAX_DWELL)) ? dwell_q : dwell_q + DW'(1);
        end else begin
            dwell_d = DW'(1);
        end

        // Checks in priority order; the lowest code wins.
        viol_code = FC_NONE;
        if (!cur_legal) begin
            viol_code = FC_ILLEGAL;
        end else if (changed && qualified && (cur_phase != next_phase)) begin
            viol_code = FC_SEQUENCE;
        end else if (changed && qualified && phase_q[0] && (dwell_q < DW'(MIN_YELLOW))) begin
            viol_code = FC_SHORT_Y;
        end else if (changed && qualified && !phase_q[0] && (dwell_q < DW'(MIN_GREEN))) begin
            viol_code = FC_SHORT_G;
        end else if (same && (dwell_q >= DW'(MAX_DWELL - 1))) begin
            // Dwell would reach MAX_DWELL on this edge.
            viol_code = FC_WATCHDOG;
        end

        state_d      = state_q;
        fault_code_d = fault_code_q;
        flash_d      = flash_q;
        flash_cnt_d  = flash_cnt_q;
        case (state_q)
            ST_IDLE: begin
                // lamp_q still holds its reset value here; no checks.
                state_d = ST_UNQUAL;
            end
            ST_UNQUAL, ST_ARMED: begin
                if (viol_code != FC_NONE) begin
                    state_d      = ST_FAULT;
                    fault_code_d = viol_code;
                    flash_d      = 1'b1;
                    flash_cnt_d  = '0;
                end else if ((state_q == ST_UNQUAL) && changed) begin
                    state_d = ST_ARMED;
                end
            end
            default: begin
                // FAULT: later violations are ignored; a clear wins over
                // anything seen in the same cycle.
                if (clear_fault) begin
                    state_d      = ST_UNQUAL;
                    fault_code_d = FC_NONE;
                    flash_d      = 1'b0;
                    flash_cnt_d  = '0;
                end else if (flash_cnt_q == FW'(FLASH_HALF - 1)) begin
                    flash_d     = ~flash_q;
                    flash_cnt_d = '0;
                end else begin
                    flash_cnt_d = flash_cnt_q + FW'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lamp_q        <= '0;
            phase_q       <= '0;
            phase_valid_q <= 1'b0;
            dwell_q       <= '0;
            state_q       <= ST_IDLE;
            fault_code_q  <= FC_NONE;
            flash_q       <= 1'b0;
            flash_cnt_q   <= '0;
        end else begin
            lamp_q        <= lamp_d;
            phase_q       <= phase_d;
            phase_valid_q <= phase_valid_d;
            dwell_q       <= dwell_d;
            state_q       <= state_d;
            fault_code_q  <= fault_code_d;
            flash_q       <= flash_d;
            flash_cnt_q   <= flash_cnt_d;
        end
    end

    assign phase       = phase_q;
    assign phase_valid = phase_valid_q;
    assign fault       = (state_q == ST_FAULT);
    assign fault_code  = fault_code_q;
    assign flash       = flash_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_traffic_conflict_monitor.sv
// Self-checking bench for traffic_conflict_monitor: directed scenarios plus
// randomized phase sequences, all compared against a behavioural model.

module tb_traffic_conflict_monitor;

    localparam int MIN_GREEN  = 8;
    localparam int MIN_YELLOW = 4;
    localparam int MAX_DWELL  = 20;
    localparam int DW         = 8;
    localparam int FLASH_HALF = 3;

    localparam logic [5:0] RG = 6'b100_001;
    localparam logic [5:0] RY = 6'b100_010;
    localparam logic [5:0] GR = 6'b001_100;
    localparam logic [5:0] YR = 6'b010_100;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [5:0] lamp_in = RG;
    logic       clear_fault = 1'b0;
    logic [1:0] phase;
    logic       phase_valid;
    logic       fault;
    logic [2:0] fault_code;
    logic       flash;
    logic [1:0] dbg_state;

    traffic_conflict_monitor #(
        .MIN_GREEN (MIN_GREEN),
        .MIN_YELLOW(MIN_YELLOW),
        .MAX_DWELL (MAX_DWELL),
        .DW        (DW),
        .FLASH_HALF(FLASH_HALF)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .r1         (lamp_in[5]),
        .y1         (lamp_in[4]),
        .g1         (lamp_in[3]),
        .r2         (lamp_in[2]),
        .y2         (lamp_in[1]),
        .g2         (lamp_in[0]),
        .clear_fault(clear_fault),
        .phase      (phase),
        .phase_valid(phase_valid),
        .fault      (fault),
        .fault_code (fault_code),
        .flash      (flash),
        .dbg_state  (dbg_state)
    );

    // clock/reset block
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Behavioural model: lamp sample register, held phase (-1 = none),
    // dwell count, fault flag/code, cycles spent in fault, qualified flag.
    logic [5:0] m_lq;
    int         m_held, m_dwell, m_code, m_age;
    bit         m_started, m_fault, m_qual;
    logic [5:0] pats [4];

    function automatic int pat_phase(input logic [5:0] p);
        if (p == RG) return 0;
        if (p == RY) return 1;
        if (p == GR) return 2;
        if (p == YR) return 3;
        return -1;
    endfunction

    task automatic model_reset();
        m_lq = 6'b0; m_held = -1; m_dwell = 0; m_code = 0; m_age = 0;
        m_started = 0; m_fault = 0; m_qual = 0;
    endtask

    task automatic model_edge(input logic [5:0] lamps, input bit clr);
        int p;
        int v;
        p = pat_phase(m_lq);
        v = 0;
        if (m_started && !m_fault) begin
            if (p < 0) v = 1;
            else if (m_held >= 0 && p != m_held) begin
                if (m_qual) begin
                    if (p != (m_held + 1) % 4) v = 2;
                    else if (m_held % 2 == 1 && m_dwell < MIN_YELLOW) v = 3;
                    else if (m_held % 2 == 0 && m_dwell < MIN_GREEN) v = 4;
                end
            end else if (m_held >= 0 && p == m_held && m_dwell + 1 >= MAX_DWELL) v = 5;
        end
        if (!m_started) m_started = 1;
        else if (m_fault) begin
            if (clr) begin m_fault = 0; m_code = 0; m_qual = 0; end
            else m_age++;
        end else if (v != 0) begin
            m_fault = 1; m_code = v; m_age = 0;
        end else if (m_held >= 0 && p >= 0 && p != m_held) m_qual = 1;
        if (p < 0) begin m_held = -1; m_dwell = 0; end
        else if (p == m_held) m_dwell = (m_dwell + 1 > MAX_DWELL) ? MAX_DWELL : m_dwell + 1;
        else begin m_held = p; m_dwell = 1; end
        m_lq = lamps;
    endtask

    task automatic compare_model();
        int exp_flash;
        exp_flash = (m_fault && ((m_age / FLASH_HALF) % 2 == 0)) ? 1 : 0;
        check_eq("fault", int'(fault), int'(m_fault));
        check_eq("fault_code", int'(fault_code), m_code);
        check_eq("flash", int'(flash), exp_flash);
        check_eq("phase_valid", int'(phase_valid), (m_held >= 0) ? 1 : 0);
        if (m_held >= 0) check_eq("phase", int'(phase), m_held);
    endtask

    // driver tasks
    task automatic step(input logic [5:0] lamps, input bit clr);
        lamp_in = lamps;
        clear_fault = clr;
        @(posedge clk);
        #1;
        clear_fault = 1'b0;
        model_edge(lamps, clr);
        compare_model();
    endtask

    task automatic hold(input logic [5:0] lamps, input int n);
        for (int i = 0; i < n; i++) step(lamps, 1'b0);
    endtask

    task automatic legal_round();
        hold(RG, 10); hold(RY, 5); hold(GR, 10); hold(YR, 5);
    endtask

    // Clear the fault and walk a full legal round so the monitor ends armed
    // at the end of YR.
    task automatic recover(input string tag);
        step(RG, 1'b1);
        check_eq({tag, "_cleared"}, int'(fault), 0);
        hold(RG, 8); hold(RY, 5); hold(GR, 10); hold(YR, 5);
        check_eq({tag, "_rearm"}, int'(fault), 0);
    endtask

    initial begin
        logic [5:0] cur;
        int         rp;
        int         r;
        int         len;
        int         flash_exp [6];
        pats[0] = RG; pats[1] = RY; pats[2] = GR; pats[3] = YR;
        flash_exp = '{1, 1, 0, 0, 0, 1};
        model_reset();

        // Reset state
        #12;
        check_eq("rst_fault", int'(fault), 0);
        check_eq("rst_code", int'(fault_code), 0);
        check_eq("rst_flash", int'(flash), 0);
        check_eq("rst_phase", int'(phase), 0);
        check_eq("rst_valid", int'(phase_valid), 0);
        reset_n = 1'b1;

        // Legal cycling, three rounds
        for (int k = 0; k < 3; k++) begin
            hold(RG, 10); check_eq("cyc_rg", int'(phase), 0);
            hold(RY, 5);  check_eq("cyc_ry", int'(phase), 1);
            hold(GR, 10); check_eq("cyc_gr", int'(phase), 2);
            hold(YR, 5);  check_eq("cyc_yr", int'(phase), 3);
        end
        check_eq("cyc_no_fault", int'(fault), 0);

        // Conflict: both greens for one cycle
        hold(RG, 10);
        step(6'b001_001, 1'b0);
        check_eq("conf_pre", int'(fault), 0);
        step(RG, 1'b0);
        check_eq("conf_fault", int'(fault), 1);
        check_eq("conf_code", int'(fault_code), 1);
        check_eq("conf_flash0", int'(flash), 1);
        for (int i = 0; i < 6; i++) begin
            step(RG, 1'b0);
            check_eq("conf_flash", int'(flash), flash_exp[i]);
        end
        recover("conf");

        // Skipped yellow
        hold(RG, 10); step(GR, 1'b0); step(GR, 1'b0);
        check_eq("skip_code", int'(fault_code), 2);
        recover("skip");

        // Short yellow
        hold(RG, 10); hold(RY, 2); step(GR, 1'b0); step(GR, 1'b0);
        check_eq("shorty_code", int'(fault_code), 3);
        recover("shorty");

        // Short green
        hold(RG, 3); step(RY, 1'b0); step(RY, 1'b0);
        check_eq("shortg_code", int'(fault_code), 4);
        recover("shortg");

        // Watchdog, then a later illegal pattern must not overwrite the code
        hold(RG, 10); hold(RY, 5); hold(GR, 20);
        check_eq("wd_pre", int'(fault), 0);
        step(GR, 1'b0);
        check_eq("wd_code", int'(fault_code), 5);
        step(6'b000_000, 1'b0); step(GR, 1'b0);
        check_eq("wd_frozen", int'(fault_code), 5);

        // Clear in the same cycle as illegal -> GR; the unqualified GR
        // may then exit after 2 cycles without a fault
        step(6'b000_111, 1'b0);
        step(GR, 1'b1);
        check_eq("clr_fault", int'(fault), 0);
        step(GR, 1'b0);
        hold(YR, 5);
        check_eq("clr_unqual_exit", int'(fault), 0);
        hold(RG, 10);

        // Asynchronous reset mid-fault while flash is high
        step(6'b001_001, 1'b0); step(RG, 1'b0);
        check_eq("ar_flash_pre", int'(flash), 1);
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("ar_fault", int'(fault), 0);
        check_eq("ar_code", int'(fault_code), 0);
        check_eq("ar_flash", int'(flash), 0);
        check_eq("ar_phase", int'(phase), 0);
        check_eq("ar_valid", int'(phase_valid), 0);
        #2;
        reset_n = 1'b1;
        model_reset();
        hold(RG, 10); hold(RY, 5);
        check_eq("ar_release", int'(fault), 0);

        // Randomized phase sequences
        rp = 1;
        cur = RY;
        for (int it = 0; it < 200; it++) begin
            r = $urandom_range(0, 99);
            if (m_fault && $urandom_range(0, 2) == 0) begin
                step(cur, 1'b1);
            end else if (r < 70) begin
                rp = (rp + 1) % 4;
                cur = pats[rp];
                len = (rp % 2 == 1) ? $urandom_range(4, 7) : $urandom_range(8, 12);
                hold(cur, len);
            end else if (r < 80) begin
                rp = $urandom_range(0, 3);
                cur = pats[rp];
                hold(cur, $urandom_range(1, 6));
            end else if (r < 88) begin
                step(6'($urandom_range(0, 63)), 1'b0);
            end else if (r < 94) begin
                hold(cur, $urandom_range(15, 22));
            end else begin
                step(cur, 1'b1);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
